// File: rtl/fpu_div_seq_pkg.sv
// Shared types for the sequential IEEE-754 divider: rounding modes, flags,
// FSM states and operand classification.
package fpu_div_seq_pkg;

    localparam int unsigned MAX_W = 128;

    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_RDN = 2'd2,
        RND_RUP = 2'd3
    } e_rnd_mode;

    typedef struct packed {
        logic invalid;
        logic div_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } st_fpu_flags;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORM_ROUND,
        S_DONE,
        S_HOLD
    } e_div_state;

    typedef enum logic [2:0] {
        FC_ZERO,
        FC_SUB,
        FC_NORM,
        FC_INF,
        FC_QNAN,
        FC_SNAN
    } e_fp_class;

    // Classify a packet zero-extended to MAX_W bits with the given field widths.
    function automatic e_fp_class fp_class(input logic [MAX_W-1:0] p,
                                           input int unsigned exp_w,
                                           input int unsigned man_w);
        logic [MAX_W-1:0] man_mask;
        logic [MAX_W-1:0] exp_mask;
        logic [MAX_W-1:0] man;
        logic [MAX_W-1:0] expo;
        logic             man_msb;
        man_mask = (MAX_W'(1) << man_w) - MAX_W'(1);
        exp_mask = (MAX_W'(1) << exp_w) - MAX_W'(1);
        man      = p & man_mask;
        expo     = (p >> man_w) & exp_mask;
        man_msb  = |(man & (MAX_W'(1) << (man_w - 1)));
        if (expo == '0) begin
            return (man == '0) ? FC_ZERO : FC_SUB;
        end
        if (expo == exp_mask) begin
            if (man == '0) begin
                return FC_INF;
            end
            return man_msb ? FC_QNAN : FC_SNAN;
        end
        return FC_NORM;
    endfunction

endpackage

// File: rtl/fpu_div_seq_if.sv
// Command/result bundle of the divider: start/cmd_end/busy handshake plus operands.
interface fpu_div_seq_if import fpu_div_seq_pkg::*; #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) ();
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic        start;
    logic [W-1:0] a_operand;
    logic [W-1:0] b_operand;
    e_rnd_mode   rnd_mode;
    logic [W-1:0] ieee_packet_out;
    st_fpu_flags flags;
    logic        cmd_end;
    logic        busy;

    modport master (
        output start, a_operand, b_operand, rnd_mode,
        input  ieee_packet_out, flags, cmd_end, busy
    );

    modport slave (
        input  start, a_operand, b_operand, rnd_mode,
        output ieee_packet_out, flags, cmd_end, busy
    );
endinterface

// File: rtl/fpu_round.sv
// Combinational rounder: applies the rounding mode to a normalised mantissa and
// resolves exponent overflow/underflow into the final packet.
module fpu_round import fpu_div_seq_pkg::*; #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                      [MAN_W:0]       mant,
    input  logic                                      guard,
    input  logic                                      sticky,
    input  logic                                      sign,
    input  logic signed               [EXP_W+1:0]     exp_in,
    input  e_rnd_mode                                 rnd_mode,
    output logic                      [EXP_W+MAN_W:0] result,
    output logic                                      overflow,
    output logic                                      underflow,
    output logic                                      inexact
);
    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned SW = MAN_W + 2;
    localparam logic signed [EW-1:0] E_OVF  = EW'(2**EXP_W - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    logic                 lost;
    logic                 round_up;
    logic                 carry;
    logic                 to_max;
    logic [SW-1:0]        sum;
    logic [MAN_W-1:0]     frac;
    logic signed [EW-1:0] e_r;

    always_comb begin
        lost     = guard | sticky;
        round_up = 1'b0;
        case (rnd_mode)
            RND_RNE: round_up = guard & (sticky | mant[0]);
            RND_RTZ: round_up = 1'b0;
            RND_RDN: round_up = sign & lost;
            default: round_up = ~sign & lost;
        endcase

        // A carry out of the mantissa leaves 1.000..0; renormalise by one.
        sum   = {1'b0, mant} + SW'(round_up);
        carry = sum[SW-1];
        frac  = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
        e_r   = exp_in + $signed({{(EW-1){1'b0}}, carry});

        overflow  = (e_r >= E_OVF);
        underflow = (e_r <= E_ZERO);
        inexact   = lost | overflow | underflow;
        to_max    = (rnd_mode == RND_RTZ) ||
                    ((rnd_mode == RND_RDN) && !sign) ||
                    ((rnd_mode == RND_RUP) && sign);

        result = {sign, e_r[EXP_W-1:0], frac};
        if (overflow) begin
            result = to_max ? {sign, EXP_W'(2**EXP_W - 2), {MAN_W{1'b1}}}
                            : {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (underflow) begin
            result = {sign, {(EXP_W+MAN_W){1'b0}}};
        end
    end
endmodule

// File: rtl/fpu_div_seq.sv
// Multi-cycle IEEE-754 divider: radix-2 restoring mantissa division, one
// quotient bit per clock, start/cmd_end/busy handshake.
module fpu_div_seq import fpu_div_seq_pkg::*; #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic         clk,
    input logic         arst,
    fpu_div_seq_if.slave bus
);
    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned QW    = MAN_W + 3;
    localparam int unsigned RW    = MAN_W + 2;
    localparam int unsigned CNT_W = $clog2(MAN_W + 4);
    localparam int unsigned BIAS  = 2**(EXP_W-1) - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAN_W + 2);
    localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    e_div_state           state;
    logic [W-1:0]         a_q, b_q, res_q;
    e_rnd_mode            rnd_q;
    st_fpu_flags          flags_q;
    logic                 busy_q, cmd_end_q;
    logic signed [EW-1:0] exp_q;
    logic [RW-1:0]        rem_q;
    logic [MAN_W:0]       div_q;
    logic [QW-1:0]        quo_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     ma, mb;
    logic                 sign;
    e_fp_class            cls_a, cls_b;
    logic                 a_nan, b_nan, a_snan, b_snan, a_zero, b_zero, a_inf, b_inf;
    logic                 special;
    logic [W-1:0]         spec_res;
    st_fpu_flags          spec_flags;

    assign ea    = a_q[W-2:MAN_W];
    assign eb    = b_q[W-2:MAN_W];
    assign ma    = a_q[MAN_W-1:0];
    assign mb    = b_q[MAN_W-1:0];
    assign sign  = a_q[W-1] ^ b_q[W-1];
    assign cls_a = fp_class(MAX_W'(a_q), EXP_W, MAN_W);
    assign cls_b = fp_class(MAX_W'(b_q), EXP_W, MAN_W);

    // Subnormals are flushed, so they classify as zero here.
    assign a_snan = (cls_a == FC_SNAN);
    assign b_snan = (cls_b == FC_SNAN);
    assign a_nan  = a_snan | (cls_a == FC_QNAN);
    assign b_nan  = b_snan | (cls_b == FC_QNAN);
    assign a_zero = (cls_a == FC_ZERO) | (cls_a == FC_SUB);
    assign b_zero = (cls_b == FC_ZERO) | (cls_b == FC_SUB);
    assign a_inf  = (cls_a == FC_INF);
    assign b_inf  = (cls_b == FC_INF);

    always_comb begin
        special    = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_res           = QNAN;
            spec_flags.invalid = a_snan | b_snan;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res           = QNAN;
            spec_flags.invalid = 1'b1;
        end else if (b_zero) begin
            spec_res            = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags.div_zero = 1'b1;
        end else if (a_inf) begin
            spec_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_inf) begin
            spec_res = {sign, {(W-1){1'b0}}};
        end else begin
            special = 1'b0;
        end
    end

    // Restoring step: keep the trial difference only when it is non-negative.
    logic [RW:0]   diff;
    logic          q_bit;
    logic [RW-1:0] rem_sel;
    assign diff    = {1'b0, rem_q} - {2'b00, div_q};
    assign q_bit   = ~diff[RW];
    assign rem_sel = q_bit ? diff[RW-1:0] : rem_q;

    logic                 q_msb;
    logic [QW-1:0]        quo_n;
    logic signed [EW-1:0] exp_n;
    logic [W-1:0]         rnd_res;
    logic                 ovf, unf, inx;
    assign q_msb = quo_q[QW-1];
    assign quo_n = q_msb ? quo_q : {quo_q[QW-2:0], 1'b0};
    assign exp_n = q_msb ? exp_q : exp_q - $signed(EW'(1));

    fpu_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .mant      (quo_n[QW-1:2]),
        .guard     (quo_n[1]),
        .sticky    (quo_n[0] | (|rem_q)),
        .sign      (sign),
        .exp_in    (exp_n),
        .rnd_mode  (rnd_q),
        .result    (rnd_res),
        .overflow  (ovf),
        .underflow (unf),
        .inexact   (inx)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rnd_q     <= RND_RNE;
            res_q     <= '0;
            flags_q   <= '0;
            busy_q    <= 1'b0;
            cmd_end_q <= 1'b0;
            exp_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a_operand;
                        b_q    <= bus.b_operand;
                        rnd_q  <= bus.rnd_mode;
                        busy_q <= 1'b1;
                        state  <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (special) begin
                        res_q     <= spec_res;
                        flags_q   <= spec_flags;
                        cmd_end_q <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        exp_q <= $signed(EW'(ea)) - $signed(EW'(eb)) + $signed(EW'(BIAS));
                        rem_q <= {1'b0, 1'b1, ma};
                        div_q <= {1'b1, mb};
                        quo_q <= '0;
                        cnt_q <= '0;
                        state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem_q <= rem_sel << 1;
                    quo_q <= {quo_q[QW-2:0], q_bit};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state <= S_NORM_ROUND;
                    end
                end
                S_NORM_ROUND: begin
                    res_q     <= rnd_res;
                    flags_q   <= '{invalid: 1'b0, div_zero: 1'b0,
                                   overflow: ovf, underflow: unf, inexact: inx};
                    cmd_end_q <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    cmd_end_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= bus.start ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    if (!bus.start) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ieee_packet_out = res_q;
    assign bus.flags           = flags_q;
    assign bus.cmd_end         = cmd_end_q;
    assign bus.busy            = busy_q;
endmodule
